// File: rtl/ddr_ser_pkg.sv
// Shared types and helpers for the hpdmc DDR output serializer.
// Optional training pattern support is enabled with `define DDR_SER_TRAIN_EN.
package ddr_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

  function automatic int slot_w(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  // Training slices alternate all-ones / all-zeros starting with ones at slice 0.
  function automatic logic train_bit(input int k);
    return ~k[0];
  endfunction

endpackage

// File: rtl/ddr_ser_buf.sv
// One-word holding register between the data FIFO and the serializer shift stage.
// Behaviour is the same whether or not DDR_SER_TRAIN_EN is defined.
module ddr_ser_buf
  import ddr_ser_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         take,
  output logic [W-1:0] data,
  output logic         full
);

  assign din_ready = ~full;

  // take only fires while full and accept only while empty, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (take) begin
      full <= 1'b0;
    end else if (din_valid && !full) begin
      data <= din;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr_out_serializer.sv
// Multi-lane output serializer: LANES*RATIO-bit words out as RATIO LANES-bit slices, slice 0 first.
// Defining DDR_SER_TRAIN_EN adds a 'train' input that substitutes a 1,0,1,0 training word at word boundaries.
module ddr_out_serializer
  import ddr_ser_pkg::*;
#(
  parameter int   LANES = 16,
  parameter int   RATIO = 2,
  parameter logic INIT  = 1'b0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   ce,
`ifdef DDR_SER_TRAIN_EN
  input  logic                   train,
`endif
  input  logic [LANES*RATIO-1:0] din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [LANES-1:0]       q,
  output logic                   q_valid,
  output logic                   q_first,
  output logic                   underrun
);

  localparam int W      = LANES * RATIO;
  localparam int SLOT_W = slot_w(RATIO);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);
  localparam logic [SLOT_W-1:0] ONE_SLOT  = SLOT_W'(1);

  logic [W-1:0]      buf_word;
  logic              buf_full;
  logic              take;
  logic              slot_zero;
  logic              load_train;
  logic [W-1:0]      next_word;
  logic [W-1:0]      sh;
  logic [SLOT_W-1:0] slot;
  ser_state_t        state;

  ddr_ser_buf #(.W(W)) u_buf (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .take      (take),
    .data      (buf_word),
    .full      (buf_full)
  );

  assign slot_zero = (slot == '0);

`ifdef DDR_SER_TRAIN_EN
  logic [W-1:0] train_word;

  always_comb begin
    train_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      train_word[k*LANES +: LANES] = {LANES{train_bit(k)}};
    end
  end

  // A training word pre-empts the buffer but leaves its contents in place.
  assign load_train = ce & slot_zero & train;
  assign next_word  = load_train ? train_word : buf_word;
`else
  assign load_train = 1'b0;
  assign next_word  = buf_word;
`endif

  assign take = ce & slot_zero & buf_full & ~load_train;

  // sh holds the not-yet-emitted slices of the word in flight, lowest slice at the bottom.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      q        <= {LANES{INIT}};
      q_valid  <= 1'b0;
      q_first  <= 1'b0;
      underrun <= 1'b0;
      slot     <= '0;
      sh       <= '0;
      state    <= IDLE;
    end else begin
      underrun <= 1'b0;
      if (ce) begin
        if (slot_zero) begin
          if (load_train || buf_full) begin
            q       <= next_word[LANES-1:0];
            sh      <= next_word >> LANES;
            q_valid <= 1'b1;
            q_first <= 1'b1;
            slot    <= ONE_SLOT;
            state   <= RUN;
          end else begin
            q        <= {LANES{INIT}};
            q_valid  <= 1'b0;
            q_first  <= 1'b0;
            underrun <= (state == RUN);
            state    <= IDLE;
          end
        end else begin
          q       <= sh[LANES-1:0];
          sh      <= sh >> LANES;
          q_first <= 1'b0;
          slot    <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_out_serializer.sv
// Scoreboard bench for ddr_out_serializer: a 16x2 INIT=1 instance and an 8x3 INIT=0 instance.
// With DDR_SER_TRAIN_EN defined the training-word sequence is exercised as well.
module tb_ddr_out_serializer;

  typedef struct packed { logic [15:0] data; logic first; } exp_a_t;
  typedef struct packed { logic [7:0]  data; logic first; } exp_b_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_a_t sb_a[$];
  exp_b_t sb_b[$];
  int seen_under_a = 0, seen_under_b = 0, exp_under_a = 0, exp_under_b = 0;
  int run_b = 0, last_run_b = 0;
  logic adv_a, adv_b;
  logic [15:0] q_hold;

  logic        rst_a_n, ce_a, din_valid_a, din_ready_a, q_valid_a, q_first_a, underrun_a;
  logic [31:0] din_a;
  logic [15:0] q_a;
  logic        rst_b_n, ce_b, din_valid_b, din_ready_b, q_valid_b, q_first_b, underrun_b;
  logic [23:0] din_b;
  logic [7:0]  q_b;
`ifdef DDR_SER_TRAIN_EN
  logic train_a, train_b;
`endif

  ddr_out_serializer #(.LANES(16), .RATIO(2), .INIT(1'b1)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_a_n),
    .ce        (ce_a),
`ifdef DDR_SER_TRAIN_EN
    .train     (train_a),
`endif
    .din       (din_a),
    .din_valid (din_valid_a),
    .din_ready (din_ready_a),
    .q         (q_a),
    .q_valid   (q_valid_a),
    .q_first   (q_first_a),
    .underrun  (underrun_a)
  );

  ddr_out_serializer #(.LANES(8), .RATIO(3), .INIT(1'b0)) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_b_n),
    .ce        (ce_b),
`ifdef DDR_SER_TRAIN_EN
    .train     (train_b),
`endif
    .din       (din_b),
    .din_valid (din_valid_b),
    .din_ready (din_ready_b),
    .q         (q_b),
    .q_valid   (q_valid_b),
    .q_first   (q_first_b),
    .underrun  (underrun_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offers one word, pushing its expected slices in emission order.
  task automatic applyStimulus(input bit to_b, input logic [31:0] w, input bit keep_valid);
    int n = 0;
    if (!to_b) begin
      while (din_ready_a !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checkOutput("a_ready_wait", {31'b0, din_ready_a}, 32'd1);
      din_a = w;
      din_valid_a = 1'b1;
      sb_a.push_back(exp_a_t'{data: w[15:0],  first: 1'b1});
      sb_a.push_back(exp_a_t'{data: w[31:16], first: 1'b0});
      @(posedge clk); #1;
      din_valid_a = keep_valid;
    end else begin
      while (din_ready_b !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checkOutput("b_ready_wait", {31'b0, din_ready_b}, 32'd1);
      din_b = w[23:0];
      din_valid_b = 1'b1;
      sb_b.push_back(exp_b_t'{data: w[7:0],   first: 1'b1});
      sb_b.push_back(exp_b_t'{data: w[15:8],  first: 1'b0});
      sb_b.push_back(exp_b_t'{data: w[23:16], first: 1'b0});
      @(posedge clk); #1;
      din_valid_b = keep_valid;
    end
  endtask

  task automatic drainQueue(input bit to_b);
    int n = 0;
    while (((to_b ? sb_b.size() : sb_a.size()) != 0) && n < 200) begin @(negedge clk); n++; end
    checkOutput(to_b ? "b_drain" : "a_drain", to_b ? sb_b.size() : sb_a.size(), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    adv_a <= ce_a;
    adv_b <= ce_b;
  end

  // Monitors: a new slice is presented only after an edge that had ce=1.
  always @(negedge clk) begin
    exp_a_t ea;
    if (underrun_a === 1'b1) seen_under_a++;
    if (adv_a === 1'b1 && q_valid_a === 1'b1) begin
      if (sb_a.size() == 0) checkOutput("a_unexpected", {31'b0, q_valid_a}, 32'd0);
      else begin
        ea = sb_a.pop_front();
        checkOutput("a_slice", {16'b0, q_a}, {16'b0, ea.data});
        checkOutput("a_first", {31'b0, q_first_a}, {31'b0, ea.first});
      end
    end
  end

  always @(negedge clk) begin
    exp_b_t eb;
    if (underrun_b === 1'b1) seen_under_b++;
    if (q_valid_b === 1'b1) run_b++;
    else begin
      if (run_b > 0) last_run_b = run_b;
      run_b = 0;
    end
    if (adv_b === 1'b1 && q_valid_b === 1'b1) begin
      if (sb_b.size() == 0) checkOutput("b_unexpected", {31'b0, q_valid_b}, 32'd0);
      else begin
        eb = sb_b.pop_front();
        checkOutput("b_slice", {24'b0, q_b}, {24'b0, eb.data});
        checkOutput("b_first", {31'b0, q_first_b}, {31'b0, eb.first});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic [7:0] s0, s1, s2;
    rst_a_n = 1'b0; rst_b_n = 1'b0; ce_a = 1'b1; ce_b = 1'b1;
    din_valid_a = 1'b0; din_valid_b = 1'b0; din_a = '0; din_b = '0;
`ifdef DDR_SER_TRAIN_EN
    train_a = 1'b0; train_b = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("a_rst_q", {16'b0, q_a}, 32'h0000FFFF);
    checkOutput("a_rst_q_valid", {31'b0, q_valid_a}, 32'd0);
    checkOutput("a_rst_din_ready", {31'b0, din_ready_a}, 32'd1);
    checkOutput("a_rst_underrun", {31'b0, underrun_a}, 32'd0);
    checkOutput("b_rst_q", {24'b0, q_b}, 32'h0);
    checkOutput("b_rst_q_valid", {31'b0, q_valid_b}, 32'd0);
    @(posedge clk); #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single word on A");
    applyStimulus(0, 32'hBEEF_1234, 1'b0);
    exp_under_a++;
    drainQueue(0);
    checkOutput("a_idle_q", {16'b0, q_a}, 32'h0000FFFF);
    checkOutput("a_idle_q_valid", {31'b0, q_valid_a}, 32'd0);
    checkOutput("a_under_single", seen_under_a, exp_under_a);

    $display("[TB] ce toggling on A");
    applyStimulus(0, 32'h5A5A_C3C3, 1'b0);
    exp_under_a++;
    q_hold = q_a;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ce_a = i[0];
      @(negedge clk);
      if (adv_a === 1'b0) checkOutput("a_ce_hold", {16'b0, q_a}, {16'b0, q_hold});
      checkOutput("a_ready_ce", {31'b0, din_ready_a}, 32'd1);
      q_hold = q_a;
    end
    @(posedge clk); #1;
    ce_a = 1'b1;
    drainQueue(0);
    checkOutput("a_under_ce", seen_under_a, exp_under_a);

`ifdef DDR_SER_TRAIN_EN
    $display("[TB] training words on A");
    train_a = 1'b1;
    din_a = 32'h7E81_0FF0;
    din_valid_a = 1'b1;
    sb_a.push_back(exp_a_t'{data: 16'hFFFF, first: 1'b1});
    sb_a.push_back(exp_a_t'{data: 16'h0000, first: 1'b0});
    sb_a.push_back(exp_a_t'{data: 16'hFFFF, first: 1'b1});
    sb_a.push_back(exp_a_t'{data: 16'h0000, first: 1'b0});
    sb_a.push_back(exp_a_t'{data: 16'h0FF0, first: 1'b1});
    sb_a.push_back(exp_a_t'{data: 16'h7E81, first: 1'b0});
    @(posedge clk); #1;
    din_valid_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    train_a = 1'b0;
    checkOutput("a_train_buf_kept", {31'b0, din_ready_a}, 32'd0);
    exp_under_a++;
    drainQueue(0);
    checkOutput("a_under_train", seen_under_a, exp_under_a);
`endif

    $display("[TB] gapless stream on B");
    for (int w = 0; w < 8; w++) begin
      s0 = 8'(3 * w);
      s1 = 8'(3 * w + 1);
      s2 = 8'(3 * w + 2);
      applyStimulus(1, {8'h00, s2, s1, s0}, w < 7);
    end
    exp_under_b++;
    drainQueue(1);
    checkOutput("b_stream_run", last_run_b, 32'd24);
    checkOutput("b_under_stream", seen_under_b, exp_under_b);

    $display("[TB] reset mid-word on B");
    applyStimulus(1, 32'h00C3_B2A1, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(q_valid_b === 1'b1 && q_first_b === 1'b1) && n < 20);
    checkOutput("b_mid_slice0", {24'b0, q_b}, 32'hA1);
    #1;
    sb_b.delete();
    rst_b_n = 1'b0;
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    @(negedge clk);
    checkOutput("b_mid_rst_q", {24'b0, q_b}, 32'h0);
    checkOutput("b_mid_rst_q_valid", {31'b0, q_valid_b}, 32'd0);
    checkOutput("b_mid_rst_first", {31'b0, q_first_b}, 32'd0);
    @(negedge clk);
    checkOutput("b_mid_no_partial", {31'b0, q_valid_b}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1, 32'h0033_2211, 1'b0);
    exp_under_b++;
    drainQueue(1);
    checkOutput("b_under_total", seen_under_b, exp_under_b);
    checkOutput("a_under_total", seen_under_a, exp_under_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
